mem_stage: RTL and testbench

Memory-access stage of the 32-bit LoongArch pipeline, between the EX/MEM register and the MEM/WB register. It issues loads and stores to the DCache over a valid/ready request channel and waits for load responses. It aligns store data and byte strobes, extracts and extends load data, and stalls upstream while an access is outstanding. Non-memory instructions pass their ALU result straight through to MEM/WB.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_stage_if.sv | 25 ++
 rtl/mem_align.sv | 50 +++++
 rtl/mem_stage.sv | 159 +++++++++++++++
 tb/tb_mem_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: machine widths,
// ex_mem_op field positions, access-size encodings and FSM states.
package mem_stage_pkg;

    localparam int WORD    = 32;
    localparam int REG_LOG = 5;

    // ex_mem_op field positions
    localparam int OP_LOAD   = 4;
    localparam int OP_STORE  = 3;
    localparam int OP_UNS    = 2;
    localparam int OP_SIZE_H = 1;
    localparam int OP_SIZE_L = 0;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_RSP = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// DCache request/response channel between mem_stage (master) and the
// data cache (slave).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic               dc_req_valid;
    logic               dc_req_ready;
    logic [WORD-1:0]    dc_req_addr;
    logic               dc_req_we;
    logic [3:0]         dc_req_wstrb;
    logic [WORD-1:0]    dc_req_wdata;
    logic               dc_resp_valid;
    logic [WORD-1:0]    dc_resp_rdata;

    modport master (
        output dc_req_valid, dc_req_addr, dc_req_we, dc_req_wstrb, dc_req_wdata,
        input  dc_req_ready, dc_resp_valid, dc_resp_rdata
    );

    modport slave (
        input  dc_req_valid, dc_req_addr, dc_req_we, dc_req_wstrb, dc_req_wdata,
        output dc_req_ready, dc_resp_valid, dc_resp_rdata
    );

endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: store strobe/data replication and load
// byte/half extraction with zero or sign extension.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]      st_off,
    input  logic [1:0]      st_size,
    input  logic [WORD-1:0] st_src,
    output logic [3:0]      st_wstrb,
    output logic [WORD-1:0] st_wdata,
    input  logic [1:0]      ld_off,
    input  logic [1:0]      ld_size,
    input  logic            ld_uns,
    input  logic [WORD-1:0] ld_rdata,
    output logic [WORD-1:0] ld_data
);

    logic signed [7:0]  ld_byte;
    logic signed [15:0] ld_half;

    // Store: replicate the source across lanes; the strobe picks the lane.
    always_comb begin
        st_wstrb = 4'hF;
        st_wdata = st_src;
        case (st_size)
            MEM_B: begin
                st_wstrb = 4'b0001 << st_off;
                st_wdata = {4{st_src[7:0]}};
            end
            MEM_H: begin
                st_wstrb = 4'b0011 << {st_off[1], 1'b0};
                st_wdata = {2{st_src[15:0]}};
            end
            default: ;
        endcase
    end

    // Load: pick the addressed lane, then extend according to ld_uns.
    always_comb begin
        ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
        ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];
        ld_data = ld_rdata;
        case (ld_size)
            MEM_B: ld_data = ld_uns ? {24'd0, ld_byte} : WORD'(ld_byte);
            MEM_H: ld_data = ld_uns ? {16'd0, ld_half} : WORD'(ld_half);
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues DCache requests, waits for load data and
// stalls upstream while an access is outstanding. Non-memory results
// pass straight through. Build option MEM_ALIGN_CHK_EN adds the
// wb_ale port and traps misaligned half/word accesses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic [4:0]         ex_mem_op,
    input  logic [WORD-1:0]    ex_addr,
    input  logic [WORD-1:0]    ex_wdata,
    input  logic [WORD-1:0]    ex_cal_res,
    input  logic [REG_LOG-1:0] ex_rd,
    output logic               mem_stall,
    mem_stage_if.master        dc,
    output logic               wb_valid,
    output logic [WORD-1:0]    wb_data,
    output logic [REG_LOG-1:0] wb_rd
`ifdef MEM_ALIGN_CHK_EN
    ,
    output logic               wb_ale
`endif
);

    mem_state_e         state_q, state_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [REG_LOG-1:0] rd_q, rd_d;

    logic            is_load, is_store, is_mem, misalign;
    logic [1:0]      ex_size;
    logic [3:0]      st_wstrb;
    logic [WORD-1:0] st_wdata, ld_data;

    // A set load bit wins if both load and store are flagged.
    assign is_load  = ex_mem_op[OP_LOAD];
    assign is_store = ex_mem_op[OP_STORE] & ~ex_mem_op[OP_LOAD];
    assign is_mem   = is_load | is_store;
    assign ex_size  = ex_mem_op[OP_SIZE_H:OP_SIZE_L];

`ifdef MEM_ALIGN_CHK_EN
    assign misalign = ((ex_size == MEM_H) && ex_addr[0]) ||
                      ((ex_size == MEM_W) && (ex_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    mem_align u_align (
        .st_off   (ex_addr[1:0]),
        .st_size  (ex_size),
        .st_src   (ex_wdata),
        .st_wstrb (st_wstrb),
        .st_wdata (st_wdata),
        .ld_off   (off_q),
        .ld_size  (size_q),
        .ld_uns   (uns_q),
        .ld_rdata (dc.dc_resp_rdata),
        .ld_data  (ld_data)
    );

    // State and load-hold registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            off_q   <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
        end
    end

    // Next state; load attributes are captured on the request handshake.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid && is_load && !misalign && dc.dc_req_ready) begin
                    state_d = S_WAIT_RSP;
                    off_d   = ex_addr[1:0];
                    size_d  = ex_size;
                    uns_d   = ex_mem_op[OP_UNS];
                    rd_d    = ex_rd;
                end
            end
            S_WAIT_RSP: begin
                if (dc.dc_resp_valid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; everything is forced quiet while rst is high.
    always_comb begin
        mem_stall       = 1'b0;
        dc.dc_req_valid = 1'b0;
        dc.dc_req_addr  = '0;
        dc.dc_req_we    = 1'b0;
        dc.dc_req_wstrb = 4'h0;
        dc.dc_req_wdata = '0;
        wb_valid        = 1'b0;
        wb_data         = '0;
        wb_rd           = '0;
`ifdef MEM_ALIGN_CHK_EN
        wb_ale          = 1'b0;
`endif
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (!is_mem) begin
                            wb_valid = 1'b1;
                            wb_data  = ex_cal_res;
                            wb_rd    = ex_rd;
                        end else if (misalign) begin
                            wb_valid = 1'b1;
                            wb_data  = ex_addr;
`ifdef MEM_ALIGN_CHK_EN
                            wb_ale   = 1'b1;
`endif
                        end else begin
                            dc.dc_req_valid = 1'b1;
                            dc.dc_req_addr  = {ex_addr[WORD-1:2], 2'b00};
                            dc.dc_req_we    = is_store;
                            dc.dc_req_wstrb = is_store ? st_wstrb : 4'h0;
                            dc.dc_req_wdata = st_wdata;
                            // A load keeps stalling after its handshake until data returns.
                            mem_stall = is_load | ~dc.dc_req_ready;
                            if (is_store && dc.dc_req_ready) wb_valid = 1'b1;
                        end
                    end
                end
                S_WAIT_RSP: begin
                    mem_stall = 1'b1;
                    if (dc.dc_resp_valid) begin
                        mem_stall = 1'b0;
                        wb_valid  = 1'b1;
                        wb_data   = ld_data;
                        wb_rd     = rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (default build, or with
// MEM_ALIGN_CHK_EN defined for the alignment-trap build).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_mem_op;
    logic [31:0] ex_addr, ex_wdata, ex_cal_res;
    logic [4:0]  ex_rd;
    logic        mem_stall, wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
`ifdef MEM_ALIGN_CHK_EN
    logic        wb_ale;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [4:0] OP_LB  = 5'b10000;
    localparam logic [4:0] OP_LH  = 5'b10001;
    localparam logic [4:0] OP_LHU = 5'b10101;
    localparam logic [4:0] OP_LW  = 5'b10010;
    localparam logic [4:0] OP_SB  = 5'b01000;
    localparam logic [4:0] OP_SH  = 5'b01001;
    localparam logic [4:0] OP_SW  = 5'b01010;

    mem_stage_if dc();

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_mem_op  (ex_mem_op),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .ex_cal_res (ex_cal_res),
        .ex_rd      (ex_rd),
        .mem_stall  (mem_stall),
        .dc         (dc.master),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd)
`ifdef MEM_ALIGN_CHK_EN
        ,
        .wb_ale     (wb_ale)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ex_valid   = 1'b0;
        ex_mem_op  = 5'd0;
        ex_addr    = 32'd0;
        ex_wdata   = 32'd0;
        ex_cal_res = 32'd0;
        ex_rd      = 5'd0;
        dc.dc_req_ready  = 1'b0;
        dc.dc_resp_valid = 1'b0;
        dc.dc_resp_rdata = 32'd0;
    endtask

    task automatic test_reset();
        step();
        rst = 1'b1; ex_valid = 1'b1; ex_mem_op = OP_LW; ex_addr = 32'h40; ex_rd = 5'd3;
        ex_cal_res = 32'h99; dc.dc_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (dc.dc_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %b want 0", dc.dc_req_valid); end
        n_cmp++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b want 0", mem_stall); end
        n_cmp++; if (wb_valid !== 1'b0 || wb_data !== 32'd0 || wb_rd !== 5'd0) begin n_fail++; $display("FAIL rst_wb got v=%b d=%h rd=%0d want 0", wb_valid, wb_data, wb_rd); end
        step();
        rst = 1'b0; quiet();
    endtask

    task automatic test_idle();
        step();
        quiet(); dc.dc_resp_valid = 1'b1; dc.dc_resp_rdata = 32'h1111_2222;
        @(negedge clk);
        n_cmp++; if ({wb_valid, mem_stall, dc.dc_req_valid} !== 3'b000) begin n_fail++; $display("FAIL idle_outs got %b want 000", {wb_valid, mem_stall, dc.dc_req_valid}); end
        n_cmp++; if (wb_data !== 32'd0) begin n_fail++; $display("FAIL idle_data got %h want 0", wb_data); end
    endtask

    task automatic test_nonmem();
        step();
        quiet(); ex_valid = 1'b1; ex_cal_res = 32'h1234; ex_rd = 5'd5;
        @(negedge clk);
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h1234 || wb_rd !== 5'd5) begin n_fail++; $display("FAIL nonmem_wb got v=%b d=%h rd=%0d want 1 1234 5", wb_valid, wb_data, wb_rd); end
        n_cmp++; if (mem_stall !== 1'b0 || dc.dc_req_valid !== 1'b0) begin n_fail++; $display("FAIL nonmem_ctl got stall=%b req=%b want 0 0", mem_stall, dc.dc_req_valid); end
    endtask

    task automatic test_store();
        // byte store to the top lane
        step();
        quiet(); ex_valid = 1'b1; ex_mem_op = OP_SB; ex_addr = 32'h1003; ex_wdata = 32'h5566_77AB;
        ex_rd = 5'd8; dc.dc_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (dc.dc_req_valid !== 1'b1 || dc.dc_req_we !== 1'b1 || dc.dc_req_addr !== 32'h1000) begin n_fail++; $display("FAIL sb_req got v=%b we=%b a=%h want 1 1 1000", dc.dc_req_valid, dc.dc_req_we, dc.dc_req_addr); end
        n_cmp++; if (dc.dc_req_wstrb !== 4'b1000 || dc.dc_req_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_lane got s=%b d=%h want 1000 abababab", dc.dc_req_wstrb, dc.dc_req_wdata); end
        n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd0 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL sb_wb got v=%b rd=%0d stall=%b want 1 0 0", wb_valid, wb_rd, mem_stall); end
        // half store with one not-ready cycle
        step();
        ex_mem_op = OP_SH; ex_addr = 32'h1002; ex_wdata = 32'h1234_BEEF; dc.dc_req_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_stall !== 1'b1 || wb_valid !== 1'b0 || dc.dc_req_valid !== 1'b1) begin n_fail++; $display("FAIL sh_wait got stall=%b wbv=%b req=%b want 1 0 1", mem_stall, wb_valid, dc.dc_req_valid); end
        step();
        dc.dc_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (dc.dc_req_wstrb !== 4'b1100 || dc.dc_req_wdata !== 32'hBEEF_BEEF) begin n_fail++; $display("FAIL sh_lane got s=%b d=%h want 1100 beefbeef", dc.dc_req_wstrb, dc.dc_req_wdata); end
        n_cmp++; if (mem_stall !== 1'b0 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL sh_done got stall=%b wbv=%b want 0 1", mem_stall, wb_valid); end
        // word store
        step();
        ex_mem_op = OP_SW; ex_addr = 32'h1008; ex_wdata = 32'hCAFE_0123;
        @(negedge clk);
        n_cmp++; if (dc.dc_req_wstrb !== 4'hF || dc.dc_req_wdata !== 32'hCAFE_0123 || dc.dc_req_addr !== 32'h1008) begin n_fail++; $display("FAIL sw_lane got s=%h d=%h a=%h want f cafe0123 1008", dc.dc_req_wstrb, dc.dc_req_wdata, dc.dc_req_addr); end
    endtask

    task automatic test_load_byte_signed();
        int stalls = 0;
        step();
        quiet(); ex_valid = 1'b1; ex_mem_op = OP_LB; ex_addr = 32'h2001; ex_rd = 5'd7;
        @(negedge clk);
        if (mem_stall) stalls++;
        n_cmp++; if (dc.dc_req_valid !== 1'b1 || dc.dc_req_we !== 1'b0 || dc.dc_req_addr !== 32'h2000) begin n_fail++; $display("FAIL lb_req got v=%b we=%b a=%h want 1 0 2000", dc.dc_req_valid, dc.dc_req_we, dc.dc_req_addr); end
        step();
        @(negedge clk);
        if (mem_stall) stalls++;
        step();
        dc.dc_req_ready = 1'b1;
        @(negedge clk);
        if (mem_stall) stalls++;
        n_cmp++; if (wb_valid !== 1'b0 || mem_stall !== 1'b1) begin n_fail++; $display("FAIL lb_hs got wbv=%b stall=%b want 0 1", wb_valid, mem_stall); end
        step();
        dc.dc_req_ready = 1'b0;
        @(negedge clk);
        if (mem_stall) stalls++;
        n_cmp++; if (dc.dc_req_valid !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL lb_wait got req=%b wbv=%b want 0 0", dc.dc_req_valid, wb_valid); end
        step();
        dc.dc_resp_valid = 1'b1; dc.dc_resp_rdata = 32'h0000_8000;
        @(negedge clk);
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_FF80 || wb_rd !== 5'd7) begin n_fail++; $display("FAIL lb_data got v=%b d=%h rd=%0d want 1 ffffff80 7", wb_valid, wb_data, wb_rd); end
        n_cmp++; if (mem_stall !== 1'b0 || stalls != 4) begin n_fail++; $display("FAIL lb_stalls got stall=%b cycles=%0d want 0 4", mem_stall, stalls); end
    endtask

    task automatic test_load_half();
        // unsigned half from upper lane
        step();
        quiet(); ex_valid = 1'b1; ex_mem_op = OP_LHU; ex_addr = 32'h2002; ex_rd = 5'd9; dc.dc_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_stall !== 1'b1 || dc.dc_req_valid !== 1'b1) begin n_fail++; $display("FAIL lhu_hs got stall=%b req=%b want 1 1", mem_stall, dc.dc_req_valid); end
        step();
        dc.dc_req_ready = 1'b0; dc.dc_resp_valid = 1'b1; dc.dc_resp_rdata = 32'hBEEF_0000;
        @(negedge clk);
        n_cmp++; if (wb_data !== 32'h0000_BEEF || wb_rd !== 5'd9 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL lhu_data got d=%h rd=%0d v=%b want 0000beef 9 1", wb_data, wb_rd, wb_valid); end
        // signed half from lower lane
        step();
        quiet(); ex_valid = 1'b1; ex_mem_op = OP_LH; ex_addr = 32'h2000; ex_rd = 5'd3; dc.dc_req_ready = 1'b1;
        step();
        dc.dc_req_ready = 1'b0; dc.dc_resp_valid = 1'b1; dc.dc_resp_rdata = 32'h1234_8001;
        @(negedge clk);
        n_cmp++; if (wb_data !== 32'hFFFF_8001 || wb_rd !== 5'd3) begin n_fail++; $display("FAIL lh_data got d=%h rd=%0d want ffff8001 3", wb_data, wb_rd); end
    endtask

    task automatic test_misalign();
        step();
        quiet(); ex_valid = 1'b1; ex_mem_op = OP_LW; ex_addr = 32'h3002; ex_rd = 5'd6; dc.dc_req_ready = 1'b1;
        @(negedge clk);
`ifdef MEM_ALIGN_CHK_EN
        n_cmp++; if (dc.dc_req_valid !== 1'b0 || wb_ale !== 1'b1 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL ale_ctl got req=%b ale=%b stall=%b want 0 1 0", dc.dc_req_valid, wb_ale, mem_stall); end
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h3002 || wb_rd !== 5'd0) begin n_fail++; $display("FAIL ale_wb got v=%b d=%h rd=%0d want 1 3002 0", wb_valid, wb_data, wb_rd); end
`else
        n_cmp++; if (dc.dc_req_valid !== 1'b1 || dc.dc_req_addr !== 32'h3000) begin n_fail++; $display("FAIL lw_mis_req got v=%b a=%h want 1 3000", dc.dc_req_valid, dc.dc_req_addr); end
        step();
        dc.dc_req_ready = 1'b0; dc.dc_resp_valid = 1'b1; dc.dc_resp_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_cmp++; if (wb_data !== 32'hCAFE_F00D || wb_rd !== 5'd6) begin n_fail++; $display("FAIL lw_mis_data got d=%h rd=%0d want cafef00d 6", wb_data, wb_rd); end
        step();
        quiet(); ex_valid = 1'b1; ex_mem_op = OP_SH; ex_addr = 32'h1003; ex_wdata = 32'h0000_BEEF; dc.dc_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (dc.dc_req_wstrb !== 4'b1100 || dc.dc_req_valid !== 1'b1) begin n_fail++; $display("FAIL sh_mis got s=%b v=%b want 1100 1", dc.dc_req_wstrb, dc.dc_req_valid); end
`endif
    endtask

    task automatic test_reset_in_wait();
        step();
        quiet(); ex_valid = 1'b1; ex_mem_op = OP_LW; ex_addr = 32'h4000; ex_rd = 5'd4; dc.dc_req_ready = 1'b1;
        step();
        dc.dc_req_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (mem_stall !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_hold got stall=%b wbv=%b want 0 0", mem_stall, wb_valid); end
        step();
        rst = 1'b0; quiet(); dc.dc_resp_valid = 1'b1; dc.dc_resp_rdata = 32'h0000_DEAD;
        @(negedge clk);
        n_cmp++; if (wb_valid !== 1'b0 || mem_stall !== 1'b0) begin n_fail++; $display("FAIL rstw_late got wbv=%b stall=%b want 0 0", wb_valid, mem_stall); end
        step();
        quiet(); ex_valid = 1'b1; ex_cal_res = 32'h55; ex_rd = 5'd2;
        @(negedge clk);
        n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h55 || wb_rd !== 5'd2) begin n_fail++; $display("FAIL rstw_idle got v=%b d=%h rd=%0d want 1 55 2", wb_valid, wb_data, wb_rd); end
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        test_reset();
        test_idle();
        test_nonmem();
        test_store();
        test_load_byte_signed();
        test_load_half();
        test_misalign();
        test_reset_in_wait();
        step();
        quiet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
